// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and defaults for the HI/LO divide sequencer.
package hilo_div_ctrl_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT = 63;
    localparam int unsigned DEF_CNT_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// CPU-side and DIVU-side signals of the HI/LO divide sequencer.
interface hilo_div_ctrl_if;
    import hilo_div_ctrl_pkg::*;

    logic              op_div;
    logic              op_divu;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              mthi;
    logic              mtlo;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              stall;
    logic              dz;
    logic              err;
    logic [DATA_W-1:0] div_dividend;
    logic [DATA_W-1:0] div_divisor;
    logic              div_start;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;
    logic              div_busy;

    modport slave (
        input  op_div, op_divu, rs_val, rt_val, mthi, mtlo, wdata,
        input  div_q, div_r, div_busy,
        output hi, lo, stall, dz, err, div_dividend, div_divisor, div_start
    );

    modport master (
        output op_div, op_divu, rs_val, rt_val, mthi, mtlo, wdata,
        output div_q, div_r, div_busy,
        input  hi, lo, stall, dz, err, div_dividend, div_divisor, div_start
    );

endinterface

// File: rtl/hilo_div_ctrl_div_sign_fix.sv
// Conditional two's-complement negate: y_c = en ? -x : x.
module hilo_div_ctrl_div_sign_fix
    import hilo_div_ctrl_pkg::*;
(
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y_c
);

    assign y_c = en ? (~x + DATA_W'(1)) : x;

endmodule

// File: rtl/hilo_div_ctrl.sv
// Sequences DIV/DIVU through the unsigned DIVU unit and owns the HI/LO registers.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic           clock,
    input  logic           reset,
    hilo_div_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [DATA_W-1:0] q_q, q_d, r_q, r_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic              start_q, start_d, dz_q, dz_d, err_q, err_d;
    logic              stall_c, req_c, cnt_hit_c;
    logic [DATA_W-1:0] abs_rs_c, abs_rt_c, q_fix_c, r_fix_c;

    // Operand magnitudes (signed ops only) and result sign correction
    hilo_div_ctrl_div_sign_fix u_abs_rs (.en(bus.op_div & bus.rs_val[DATA_W-1]), .x(bus.rs_val), .y_c(abs_rs_c));
    hilo_div_ctrl_div_sign_fix u_abs_rt (.en(bus.op_div & bus.rt_val[DATA_W-1]), .x(bus.rt_val), .y_c(abs_rt_c));
    hilo_div_ctrl_div_sign_fix u_fix_q  (.en(qneg_q), .x(q_q), .y_c(q_fix_c));
    hilo_div_ctrl_div_sign_fix u_fix_r  (.en(rneg_q), .x(r_q), .y_c(r_fix_c));

    assign req_c     = bus.op_div | bus.op_divu;
    assign cnt_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            start_q <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            start_q <= start_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        start_d = 1'b0;
        dz_d    = 1'b0;
        err_d   = 1'b0;
        stall_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    // Request beats MTHI/MTLO; zero divisor is a flagged no-op
                    if (bus.rt_val != '0) begin
                        qneg_d  = bus.op_div & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
                        rneg_d  = bus.op_div & bus.rs_val[DATA_W-1];
                        dvd_d   = abs_rs_c;
                        dvs_d   = abs_rt_c;
                        start_d = 1'b1;
                        stall_c = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        dz_d = 1'b1;
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            ST_ISSUE: begin
                stall_c = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                stall_c = 1'b1;
                if (bus.div_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_hit_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                stall_c = 1'b1;
                if (!bus.div_busy) begin
                    q_d     = bus.div_q;
                    r_d     = bus.div_r;
                    state_d = ST_WRITEBACK;
                end else if (cnt_hit_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                lo_d    = q_fix_c;
                hi_d    = r_fix_c;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.stall        = stall_c;
    assign bus.dz           = dz_q;
    assign bus.err          = err_q;
    assign bus.div_start    = start_q;
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural DIVU responder.
module tb_hilo_div_ctrl;

    localparam int unsigned TIMEOUT = 63;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    logic hang;

    hilo_div_ctrl_if bus ();

    hilo_div_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DIVU responder: busy for lat cycles after start, result then appears with busy low
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_q, m_r, p_q, p_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
            p_q    <= '0;
            p_r    <= '0;
        end else if (bus.div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_q    <= $urandom;
            m_r    <= $urandom;
            p_q    <= (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : 32'hFFFF_FFFF;
            p_r    <= (bus.div_divisor != 0) ? bus.div_dividend % bus.div_divisor : bus.div_dividend;
        end else if (m_busy && !hang) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                m_q    <= p_q;
                m_r    <= p_r;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end
    assign bus.div_busy = m_busy;
    assign bus.div_q    = m_q;
    assign bus.div_r    = m_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result: C-style truncating signed divide, plain unsigned divide
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && $signed(x) < 0) ? 32'(0 - x) : x;
    endfunction

    // One full divide; inputs (incl. ignored MTHI/MTLO) held while stalled
    task automatic run_div(input logic sgn, input logic both, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input string name);
        int stalls;
        int starts;
        bit done;
        stalls = 0;
        starts = 0;
        done   = 0;
        bus.op_div  = sgn;
        bus.op_divu = !sgn || both;
        bus.rs_val  = a;
        bus.rt_val  = b;
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wdata   = $urandom;
        for (int i = 0; i < 80 && !done; i++) begin
            #1;
            if (bus.div_start) starts++;
            if (bus.stall) stalls++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_start_cycles"}, 32'(starts), 32'd1);
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(lat + 3));
        chk({name, "_dividend"}, bus.div_dividend, mag(sgn, a));
        chk({name, "_divisor"}, bus.div_divisor, mag(sgn, b));
        bus.op_div  = 1'b0;
        bus.op_divu = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        @(negedge clk);
        chk({name, "_hi"}, bus.hi, exp_hi);
        chk({name, "_lo"}, bus.lo, exp_lo);
        chk({name, "_stall_after"}, 32'(bus.stall), 32'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic        both;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, eq, er;
        logic        sgn;
        int          n;
        bit          seen;

        checks = 0;
        failures = 0;
        hang = 1'b0;
        lat = 2;
        rst_n = 1'b0;
        bus.op_div = 1'b0;
        bus.op_divu = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        bus.wdata = '0;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_7FFF, 32'h0000_0010, 32'h0000_000F, 32'h0000_07FF, 1};
        tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0003, 32'h0000_0002, 32'h5555_5552, 3};
        tbl[2] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 2};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 4};
        tbl[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 2};
        tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000, 1};

        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_dz", 32'(bus.dz), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_start", 32'(bus.div_start), 32'd0);
        chk("rst_dividend", bus.div_dividend, 32'h0);
        chk("rst_divisor", bus.div_divisor, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI then MTLO, then a zero-divisor request that also carries an ignored MTHI
        bus.mthi = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'hABCD;
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mt_hi", bus.hi, 32'h1234);
        chk("mt_lo", bus.lo, 32'hABCD);
        bus.op_div = 1'b1; bus.rs_val = 32'd5; bus.rt_val = 32'd0;
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD;
        #1 chk("dz_stall_req", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.op_div = 1'b0; bus.mthi = 1'b0;
        #1;
        chk("dz_pulse", 32'(bus.dz), 32'd1);
        chk("dz_hi", bus.hi, 32'h1234);
        chk("dz_lo", bus.lo, 32'hABCD);
        chk("dz_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("dz_one_cycle", 32'(bus.dz), 32'd0);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h5A5A_A5A5;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mt_both_hi", bus.hi, 32'h5A5A_A5A5);
        chk("mt_both_lo", bus.lo, 32'h5A5A_A5A5);

        for (int i = 0; i < 7; i++) begin
            lat = tbl[i].lat;
            run_div(tbl[i].sgn, tbl[i].both, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 30);
            if (sgn && $urandom_range(0, 3) == 0) b = 32'(0 - (b >> 24));
            if (b == 0) b = 32'd3;
            lat = $urandom_range(1, 6);
            ref_div(sgn, a, b, eq, er);
            run_div(sgn, 1'b0, a, b, er, eq, $sformatf("rnd%0d", i));
        end

        // Reset while DIVU is busy, then a clean divide
        lat = 8;
        bus.op_divu = 1'b1; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.op_divu = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_start", 32'(bus.div_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat = 3;
        run_div(1'b0, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "post_rst");

        // DIVU stuck busy: watchdog must abort and leave HI/LO alone
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        hang = 1'b1;
        bus.op_divu = 1'b1; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
        @(negedge clk);
        bus.op_divu = 1'b0;
        n = 1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (bus.err) seen = 1;
        end
        chk("to_err_seen", 32'(seen), 32'd1);
        chk("to_err_window", 32'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 4), 32'd1);
        #1;
        chk("to_stall", 32'(bus.stall), 32'd0);
        chk("to_hi", bus.hi, 32'h0F0F_0F0F);
        chk("to_lo", bus.lo, 32'h0F0F_0F0F);
        @(negedge clk);
        chk("to_err_one_cycle", 32'(bus.err), 32'd0);
        chk("to_stall_idle", 32'(bus.stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
